// File: rtl/exu_pkg.sv
// exu_pkg: opcode map, stage FSM states and memory-op decode helpers shared by
// exu_stage and exu_muldiv. The MUL/DIV opcodes exist in every build; they are
// only executed when the stage is built with EXU_MULDIV_EN.
package exu_pkg;

    localparam logic [7:0] ALU_OP_ADD   = 8'h01;
    localparam logic [7:0] ALU_OP_SUB   = 8'h02;
    localparam logic [7:0] ALU_OP_AND   = 8'h03;
    localparam logic [7:0] ALU_OP_OR    = 8'h04;
    localparam logic [7:0] ALU_OP_XOR   = 8'h05;
    localparam logic [7:0] ALU_OP_SLT   = 8'h06;
    localparam logic [7:0] ALU_OP_SLTU  = 8'h07;
    localparam logic [7:0] ALU_OP_SLL   = 8'h08;
    localparam logic [7:0] ALU_OP_SRL   = 8'h09;
    localparam logic [7:0] ALU_OP_SRA   = 8'h0A;
    localparam logic [7:0] ALU_OP_JUMP  = 8'h0B;

    localparam logic [7:0] ALU_OP_LB    = 8'h10;
    localparam logic [7:0] ALU_OP_LH    = 8'h11;
    localparam logic [7:0] ALU_OP_LW    = 8'h12;
    localparam logic [7:0] ALU_OP_LBU   = 8'h13;
    localparam logic [7:0] ALU_OP_LHU   = 8'h14;
    localparam logic [7:0] ALU_OP_LWU   = 8'h15;
    localparam logic [7:0] ALU_OP_LD    = 8'h16;
    localparam logic [7:0] ALU_OP_SB    = 8'h18;
    localparam logic [7:0] ALU_OP_SH    = 8'h19;
    localparam logic [7:0] ALU_OP_SW    = 8'h1A;
    localparam logic [7:0] ALU_OP_SD    = 8'h1B;

    localparam logic [7:0] ALU_OP_MUL   = 8'h20;
    localparam logic [7:0] ALU_OP_MULHU = 8'h21;
    localparam logic [7:0] ALU_OP_DIV   = 8'h22;
    localparam logic [7:0] ALU_OP_DIVU  = 8'h23;
    localparam logic [7:0] ALU_OP_REM   = 8'h24;
    localparam logic [7:0] ALU_OP_REMU  = 8'h25;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} exu_state_t;

    // Access size in bytes; 0 for non-memory ops and for 64-bit-only ops on RV32.
    function automatic logic [3:0] mem_size(input logic [31:0] op, input logic rv64);
        logic [3:0] sz;
        sz = 4'd0;
        case (op)
            32'(ALU_OP_LB), 32'(ALU_OP_LBU), 32'(ALU_OP_SB): sz = 4'd1;
            32'(ALU_OP_LH), 32'(ALU_OP_LHU), 32'(ALU_OP_SH): sz = 4'd2;
            32'(ALU_OP_LW), 32'(ALU_OP_SW):                  sz = 4'd4;
            32'(ALU_OP_LWU):                                 sz = rv64 ? 4'd4 : 4'd0;
            32'(ALU_OP_LD), 32'(ALU_OP_SD):                  sz = rv64 ? 4'd8 : 4'd0;
            default:                                         sz = 4'd0;
        endcase
        return sz;
    endfunction

    function automatic logic is_load(input logic [31:0] op, input logic rv64);
        logic ld;
        ld = (op == 32'(ALU_OP_LB)) || (op == 32'(ALU_OP_LH)) || (op == 32'(ALU_OP_LW)) ||
             (op == 32'(ALU_OP_LBU)) || (op == 32'(ALU_OP_LHU)) ||
             (op == 32'(ALU_OP_LWU)) || (op == 32'(ALU_OP_LD));
        return ld && (mem_size(op, rv64) != 4'd0);
    endfunction

    function automatic logic is_store(input logic [31:0] op, input logic rv64);
        logic st;
        st = (op == 32'(ALU_OP_SB)) || (op == 32'(ALU_OP_SH)) ||
             (op == 32'(ALU_OP_SW)) || (op == 32'(ALU_OP_SD));
        return st && (mem_size(op, rv64) != 4'd0);
    endfunction

    function automatic logic is_muldiv(input logic [31:0] op);
        return (op == 32'(ALU_OP_MUL))  || (op == 32'(ALU_OP_MULHU)) ||
               (op == 32'(ALU_OP_DIV))  || (op == 32'(ALU_OP_DIVU))  ||
               (op == 32'(ALU_OP_REM))  || (op == 32'(ALU_OP_REMU));
    endfunction

endpackage

// File: rtl/exu_muldiv.sv
// exu_muldiv: iterative unit, one bit per cycle for XLEN cycles.
// Multiply is shift-add into {hi,lo}; divide is restoring, remainder in hi and
// quotient shifting into lo. Signed DIV/REM run on magnitudes and the sign is
// applied on the combinational result once the iterations are finished.
// Only instantiated when EXU_MULDIV_EN is defined.
module exu_muldiv
    import exu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [7:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            busy_o,
    output logic            last_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);
    localparam int CW = $clog2(XLEN);

    logic            busy_q, done_q, mul_q, neg_q, rneg_q, bz_q;
    logic [CW-1:0]   cnt_q;
    logic [7:0]      op_q;
    logic [XLEN-1:0] hi_q, lo_q, b_q;
    logic [XLEN-1:0] hi_d, lo_d;
    logic [XLEN:0]   sum, tmp;

    logic            sgn, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;

    assign sgn   = (op_i == ALU_OP_DIV) || (op_i == ALU_OP_REM);
    assign a_neg = sgn & a_i[XLEN-1];
    assign b_neg = sgn & b_i[XLEN-1];
    assign a_mag = a_neg ? -a_i : a_i;
    assign b_mag = b_neg ? -b_i : b_i;

    // One iteration of shift-add multiply or restoring divide
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        sum  = '0;
        tmp  = '0;
        if (mul_q) begin
            sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
            hi_d = sum[XLEN:1];
            lo_d = {sum[0], lo_q[XLEN-1:1]};
        end else begin
            tmp = {hi_q, lo_q[XLEN-1]};
            if (tmp >= {1'b0, b_q}) begin
                tmp  = tmp - {1'b0, b_q};
                lo_d = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                lo_d = {lo_q[XLEN-2:0], 1'b0};
            end
            hi_d = tmp[XLEN-1:0];
        end
    end

    // Operand capture on start, then XLEN iterations counting down to 0
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            mul_q  <= 1'b0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            bz_q   <= 1'b0;
            cnt_q  <= '0;
            op_q   <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            b_q    <= '0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                busy_q <= 1'b1;
                cnt_q  <= CW'(XLEN - 1);
                op_q   <= op_i;
                mul_q  <= (op_i == ALU_OP_MUL) || (op_i == ALU_OP_MULHU);
                neg_q  <= a_neg ^ b_neg;
                rneg_q <= a_neg;
                bz_q   <= (b_i == '0);
                hi_q   <= '0;
                lo_q   <= a_mag;
                b_q    <= b_mag;
            end else if (busy_q) begin
                hi_q  <= hi_d;
                lo_q  <= lo_d;
                cnt_q <= cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    // Result selection with sign fix-up; divide-by-zero quotient is all-ones
    always_comb begin
        result_o = '0;
        case (op_q)
            ALU_OP_MUL:   result_o = lo_q;
            ALU_OP_MULHU: result_o = hi_q;
            ALU_OP_DIVU:  result_o = lo_q;
            ALU_OP_REMU:  result_o = hi_q;
            ALU_OP_DIV:   result_o = bz_q ? '1 : (neg_q ? -lo_q : lo_q);
            ALU_OP_REM:   result_o = rneg_q ? -hi_q : hi_q;
            default:      result_o = '0;
        endcase
    end

    assign busy_o = busy_q;
    assign last_o = busy_q && (cnt_q == '0);
    assign done_o = done_q;

endmodule

// File: rtl/exu_stage.sv
// exu_stage: handshaked, registered execute stage. Single-cycle ALU, load/store
// address, byte-lane mask and misalignment flags; results held in an output
// register until the consumer takes them.
// Build option EXU_MULDIV_EN: adds the iterative MUL/DIV path (IDLE/BUSY/DONE);
// without it the MUL/DIV opcodes report illegal_o like any unknown op.
module exu_stage
    import exu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 8,
    parameter int INST_LEN = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [ALU_OP_W-1:0]           alu_op_i,
    input  logic [XLEN-1:0]               operand1_i,
    input  logic [XLEN-1:0]               operand2_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [XLEN-1:0]               alu_result_o,
    output logic [ALU_OP_W-1:0]           alu_op_o,
    output logic                          rmem_ena_o,
    output logic [XLEN-1:0]               rmem_addr_o,
    output logic                          wmem_ena_o,
    output logic [XLEN-1:0]               wmem_addr_o,
    output logic [XLEN/8-1:0]             wmem_mask_o,
    output logic [$clog2(XLEN/8)-1:0]     mem_offset_o,
    output logic                          misalign_o,
    output logic                          illegal_o
);
    localparam int   MASKW = XLEN / 8;
    localparam int   OFFW  = $clog2(MASKW);
    localparam int   SHW   = $clog2(XLEN);
    localparam logic RV64  = (XLEN == 64);

    logic [31:0]         op32;
    logic [SHW-1:0]      shamt;
    logic [XLEN-1:0]     addr;
    logic [3:0]          size;
    logic                ld, st, is_md, accept, load_single, load_md;
    logic [XLEN-1:0]     res_d;
    logic                ill_d, mis_d;
    logic [OFFW-1:0]     off_d;
    logic [MASKW:0]      ones;
    logic [MASKW-1:0]    mask_d;
    logic [XLEN-1:0]     md_result;
    logic [ALU_OP_W-1:0] md_op;

    logic                vld_q, rena_q, wena_q, mis_q, ill_q;
    logic [XLEN-1:0]     res_q, raddr_q, waddr_q;
    logic [ALU_OP_W-1:0] op_q;
    logic [MASKW-1:0]    mask_q;
    logic [OFFW-1:0]     off_q;

    assign op32   = 32'(alu_op_i);
    assign shamt  = operand2_i[SHW-1:0];
    assign addr   = operand1_i + operand2_i;
    assign size   = mem_size(op32, RV64);
    assign ld     = is_load(op32, RV64);
    assign st     = is_store(op32, RV64);
    assign accept = in_valid_i & in_ready_o;
    assign load_single = accept & ~is_md;

    // Single-cycle ALU and memory-op decode of the presented operation
    always_comb begin
        res_d  = '0;
        ill_d  = 1'b0;
        off_d  = '0;
        mis_d  = 1'b0;
        mask_d = '0;
        ones   = ((MASKW+1)'(1) << size) - (MASKW+1)'(1);
        case (op32)
            32'(ALU_OP_ADD):  res_d = operand1_i + operand2_i;
            32'(ALU_OP_SUB):  res_d = operand1_i - operand2_i;
            32'(ALU_OP_AND):  res_d = operand1_i & operand2_i;
            32'(ALU_OP_OR):   res_d = operand1_i | operand2_i;
            32'(ALU_OP_XOR):  res_d = operand1_i ^ operand2_i;
            32'(ALU_OP_SLT):  res_d = {{(XLEN-1){1'b0}}, $signed(operand1_i) < $signed(operand2_i)};
            32'(ALU_OP_SLTU): res_d = {{(XLEN-1){1'b0}}, operand1_i < operand2_i};
            32'(ALU_OP_SLL):  res_d = operand1_i << shamt;
            32'(ALU_OP_SRL):  res_d = operand1_i >> shamt;
            32'(ALU_OP_SRA):  res_d = $unsigned($signed(operand1_i) >>> shamt);
            32'(ALU_OP_JUMP): res_d = XLEN'(INST_LEN) + operand2_i;
            default:          ill_d = ~(ld | st | is_md);
        endcase
        if (ld | st) begin
            off_d = addr[OFFW-1:0];
            mis_d = |(OFFW'(size - 4'd1) & off_d);
            if (st && !mis_d)
                mask_d = MASKW'(ones << off_d);
        end
    end

`ifdef EXU_MULDIV_EN
    exu_state_t          state_q, state_d;
    logic                md_busy, md_last, md_done;
    logic [ALU_OP_W-1:0] md_op_q;

    assign is_md      = is_muldiv(op32);
    assign in_ready_o = (state_q == IDLE) & (~vld_q | out_ready_i);
    assign load_md    = (state_q == DONE) & md_done;
    assign md_op      = md_op_q;

    exu_muldiv #(.XLEN(XLEN)) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .start_i  (accept & is_md),
        .op_i     (op32[7:0]),
        .a_i      (operand1_i),
        .b_i      (operand2_i),
        .busy_o   (md_busy),
        .last_o   (md_last),
        .done_o   (md_done),
        .result_o (md_result)
    );

    // Stage FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state: IDLE -> BUSY on a mul/div accept, BUSY -> DONE on last iteration
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && is_md) state_d = BUSY;
            BUSY:    if (!md_busy)        state_d = IDLE;
                     else if (md_last)    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Opcode of the in-flight mul/div, reported with its result
    always_ff @(posedge clk) begin
        if (rst)                md_op_q <= '0;
        else if (accept & is_md) md_op_q <= alu_op_i;
    end
`else
    assign is_md      = 1'b0;
    assign in_ready_o = ~vld_q | out_ready_i;
    assign load_md    = 1'b0;
    assign md_result  = '0;
    assign md_op      = '0;
`endif

    // Output register: load on single-cycle accept or mul/div completion, clear valid on handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q   <= 1'b0;
            res_q   <= '0;
            op_q    <= '0;
            rena_q  <= 1'b0;
            raddr_q <= '0;
            wena_q  <= 1'b0;
            waddr_q <= '0;
            mask_q  <= '0;
            off_q   <= '0;
            mis_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else if (load_single) begin
            vld_q   <= 1'b1;
            res_q   <= res_d;
            op_q    <= alu_op_i;
            rena_q  <= ld;
            raddr_q <= ld ? addr : '0;
            wena_q  <= st;
            waddr_q <= st ? addr : '0;
            mask_q  <= mask_d;
            off_q   <= off_d;
            mis_q   <= mis_d;
            ill_q   <= ill_d;
        end else if (load_md) begin
            vld_q   <= 1'b1;
            res_q   <= md_result;
            op_q    <= md_op;
            rena_q  <= 1'b0;
            raddr_q <= '0;
            wena_q  <= 1'b0;
            waddr_q <= '0;
            mask_q  <= '0;
            off_q   <= '0;
            mis_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else if (out_ready_i) begin
            vld_q   <= 1'b0;
        end
    end

    assign out_valid_o  = vld_q;
    assign alu_result_o = res_q;
    assign alu_op_o     = op_q;
    assign rmem_ena_o   = rena_q;
    assign rmem_addr_o  = raddr_q;
    assign wmem_ena_o   = wena_q;
    assign wmem_addr_o  = waddr_q;
    assign wmem_mask_o  = mask_q;
    assign mem_offset_o = off_q;
    assign misalign_o   = mis_q;
    assign illegal_o    = ill_q;

endmodule

// File: tb/tb_exu_stage.sv
// Bench for exu_stage: XLEN=32 instance driven from a vector table through a
// scoreboard, plus a small XLEN=64 instance for the wide memory ops.
// EXU_MULDIV_EN selects the mul/div checks versus the illegal-op checks.
module tb_exu_stage;
    import exu_pkg::*;

    localparam int XLEN = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic [7:0]  alu_op, op_out;
    logic [31:0] op1, op2, result, raddr, waddr;
    logic        rena, wena, mis, ill;
    logic [3:0]  mask;
    logic [1:0]  off;

    exu_stage #(.XLEN(32), .ALU_OP_W(8), .INST_LEN(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .alu_op_i(alu_op), .operand1_i(op1), .operand2_i(op2),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .alu_result_o(result), .alu_op_o(op_out),
        .rmem_ena_o(rena), .rmem_addr_o(raddr), .wmem_ena_o(wena), .wmem_addr_o(waddr),
        .wmem_mask_o(mask), .mem_offset_o(off), .misalign_o(mis), .illegal_o(ill)
    );

    logic        iv64, ir64, ov64, rena64, wena64, mis64, ill64;
    logic [7:0]  op64, opo64;
    logic [63:0] a64, b64, res64, raddr64, waddr64;
    logic [7:0]  mask64;
    logic [2:0]  off64;

    exu_stage #(.XLEN(64), .ALU_OP_W(8), .INST_LEN(4)) u_dut64 (
        .clk(clk), .rst(rst), .in_valid_i(iv64), .in_ready_o(ir64),
        .alu_op_i(op64), .operand1_i(a64), .operand2_i(b64),
        .out_valid_o(ov64), .out_ready_i(1'b1),
        .alu_result_o(res64), .alu_op_o(opo64),
        .rmem_ena_o(rena64), .rmem_addr_o(raddr64), .wmem_ena_o(wena64), .wmem_addr_o(waddr64),
        .wmem_mask_o(mask64), .mem_offset_o(off64), .misalign_o(mis64), .illegal_o(ill64)
    );

    typedef struct {
        logic [7:0]  op;
        logic [31:0] a, b, res;
        logic        rena, wena;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [1:0]  off;
        logic        mis, ill;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] op, input logic [31:0] a, b, res,
                                input logic rd, wr, input logic [31:0] ad, input logic [3:0] mk_,
                                input logic [1:0] of, input logic ms, il);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.res = res; v.rena = rd; v.wena = wr;
        v.addr = ad; v.mask = mk_; v.off = of; v.mis = ms; v.ill = il;
        return v;
    endfunction

    function automatic vec_t alu(input logic [7:0] op, input logic [31:0] a, b, res);
        return mk(op, a, b, res, 1'b0, 1'b0, 32'h0, 4'h0, 2'd0, 1'b0, 1'b0);
    endfunction

    // Scoreboard: every completed handshake is checked against the oldest expectation
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 64'(result), 64'hDEAD);
            end else begin
                vec_t e;
                e = sb.pop_front();
                chk($sformatf("result op%0h", e.op), 64'(result), 64'(e.res));
                chk($sformatf("alu_op op%0h", e.op), 64'(op_out), 64'(e.op));
                chk($sformatf("rmem op%0h", e.op), {31'h0, rena, raddr}, {31'h0, e.rena, (e.rena ? e.addr : 32'h0)});
                chk($sformatf("wmem op%0h", e.op), {31'h0, wena, waddr}, {31'h0, e.wena, (e.wena ? e.addr : 32'h0)});
                chk($sformatf("mask_off op%0h", e.op), {58'h0, mask, off}, {58'h0, e.mask, e.off});
                chk($sformatf("flags op%0h", e.op), {62'h0, mis, ill}, {62'h0, e.mis, e.ill});
            end
        end
    end

    task automatic send(input vec_t v);
        int n;
        @(posedge clk); #1;
        in_valid = 1'b1; alu_op = v.op; op1 = v.a; op2 = v.b;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("accept_timeout", 64'd0, 64'd1);
        else          sb.push_back(v);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    task automatic t64(input string name, input logic [7:0] op, input logic [63:0] a, b, res,
                       input logic [7:0] emask, input logic [2:0] eoff, input logic ewr, erd, emis, eill);
        @(posedge clk); #1;
        iv64 = 1'b1; op64 = op; a64 = a; b64 = b;
        @(negedge clk);
        chk($sformatf("%s_ready", name), 64'(ir64), 64'd1);
        @(posedge clk); #1;
        iv64 = 1'b0;
        @(negedge clk);
        chk($sformatf("%s_valid", name), 64'(ov64), 64'd1);
        chk($sformatf("%s_result", name), res64, res);
        chk($sformatf("%s_mask_off", name), {53'h0, mask64, off64}, {53'h0, emask, eoff});
        chk($sformatf("%s_flags", name), {60'h0, wena64, rena64, mis64, ill64}, {60'h0, ewr, erd, emis, eill});
    endtask

    initial begin
        int lat, bad;
        logic [31:0] ra, rb;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; alu_op = '0; op1 = '0; op2 = '0;
        iv64 = 1'b0; op64 = '0; a64 = '0; b64 = '0;

        tbl.push_back(alu(ALU_OP_SRA,  32'h8000_0000, 32'd4, 32'hF800_0000));
        tbl.push_back(alu(ALU_OP_SLTU, 32'd1, 32'd2, 32'd1));
        tbl.push_back(alu(ALU_OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0));
        tbl.push_back(alu(ALU_OP_SLT,  32'hFFFF_FFFF, 32'd1, 32'd1));
        tbl.push_back(alu(ALU_OP_SUB,  32'd3, 32'd5, 32'hFFFF_FFFE));
        tbl.push_back(alu(ALU_OP_ADD,  32'hFFFF_FFFF, 32'd1, 32'd0));
        tbl.push_back(alu(ALU_OP_SLL,  32'd1, 32'h25, 32'h20));
        tbl.push_back(alu(ALU_OP_SRL,  32'h8000_0000, 32'd31, 32'd1));
        tbl.push_back(alu(ALU_OP_AND,  32'hF0F0, 32'hFF00, 32'hF000));
        tbl.push_back(alu(ALU_OP_OR,   32'hF0F0, 32'hFF00, 32'hFFF0));
        tbl.push_back(alu(ALU_OP_XOR,  32'hF0F0, 32'hFF00, 32'h0FF0));
        tbl.push_back(alu(ALU_OP_JUMP, 32'h1234, 32'h100, 32'h104));
        tbl.push_back(mk(ALU_OP_SH,  32'h1000, 32'd2, 32'h0, 1'b0, 1'b1, 32'h1002, 4'b1100, 2'd2, 1'b0, 1'b0));
        tbl.push_back(mk(ALU_OP_SW,  32'h1001, 32'd0, 32'h0, 1'b0, 1'b1, 32'h1001, 4'b0000, 2'd1, 1'b1, 1'b0));
        tbl.push_back(mk(ALU_OP_SB,  32'h10, 32'd3, 32'h0, 1'b0, 1'b1, 32'h13, 4'b1000, 2'd3, 1'b0, 1'b0));
        tbl.push_back(mk(ALU_OP_SW,  32'hFFFF_FFFC, 32'd8, 32'h0, 1'b0, 1'b1, 32'h4, 4'b1111, 2'd0, 1'b0, 1'b0));
        tbl.push_back(mk(ALU_OP_LW,  32'h2000, 32'd4, 32'h0, 1'b1, 1'b0, 32'h2004, 4'b0000, 2'd0, 1'b0, 1'b0));
        tbl.push_back(mk(ALU_OP_LBU, 32'h2000, 32'd3, 32'h0, 1'b1, 1'b0, 32'h2003, 4'b0000, 2'd3, 1'b0, 1'b0));
        tbl.push_back(mk(ALU_OP_LH,  32'h2001, 32'd0, 32'h0, 1'b1, 1'b0, 32'h2001, 4'b0000, 2'd1, 1'b1, 1'b0));
        tbl.push_back(mk(8'hFF,      32'd9, 32'd9, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 2'd0, 1'b0, 1'b1));
        tbl.push_back(mk(ALU_OP_LD,  32'h100, 32'd0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 2'd0, 1'b0, 1'b1));
`ifdef EXU_MULDIV_EN
        tbl.push_back(alu(ALU_OP_MUL,   32'd3, 32'd4, 32'd12));
        tbl.push_back(alu(ALU_OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE));
        tbl.push_back(alu(ALU_OP_DIV,   32'd5, 32'd0, 32'hFFFF_FFFF));
        tbl.push_back(alu(ALU_OP_REM,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF));
        tbl.push_back(alu(ALU_OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000));
        tbl.push_back(alu(ALU_OP_REM,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0));
        tbl.push_back(alu(ALU_OP_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD));
        tbl.push_back(alu(ALU_OP_REMU,  32'd100, 32'd7, 32'd2));
        tbl.push_back(alu(ALU_OP_REM,   32'hFFFF_FFFA, 32'd0, 32'hFFFF_FFFA));
        tbl.push_back(alu(ALU_OP_DIVU,  32'd9, 32'd0, 32'hFFFF_FFFF));
`else
        tbl.push_back(mk(ALU_OP_DIV, 32'd5, 32'd0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 2'd0, 1'b0, 1'b1));
`endif

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        @(negedge clk);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_result", 64'(result), 64'd0);
        chk("reset_flags", {57'h0, rena, wena, mask, ill}, 64'd0);

        // single-cycle latency: ADD 5+7
        send(alu(ALU_OP_ADD, 32'd5, 32'd7, 32'd12));
        @(negedge clk);
        chk("add_latency_valid", 64'(out_valid), 64'd1);

        foreach (tbl[i]) send(tbl[i]);
        drain();

        for (int i = 0; i < 6; i++) begin
            ra = $urandom; rb = $urandom;
            send(alu((i % 2) ? ALU_OP_SUB : ALU_OP_ADD, ra, rb, (i % 2) ? ra - rb : ra + rb));
        end
        drain();

        // backpressure: ADD held while SUB waits
        @(posedge clk); #1 out_ready = 1'b0;
        send(alu(ALU_OP_ADD, 32'd10, 32'd20, 32'd30));
        @(posedge clk); #1;
        in_valid = 1'b1; alu_op = ALU_OP_SUB; op1 = 32'd50; op2 = 32'd8;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_hold", {31'h0, out_valid, result}, {31'h0, 1'b1, 32'd30});
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_after", 64'(in_ready), 64'd1);
        sb.push_back(alu(ALU_OP_SUB, 32'd50, 32'd8, 32'd42));
        @(posedge clk); #1 in_valid = 1'b0;
        drain();

`ifndef EXU_MULDIV_EN
        // MUL compiled out: illegal, single cycle
        send(mk(ALU_OP_MUL, 32'd3, 32'd4, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 2'd0, 1'b0, 1'b1));
        @(negedge clk);
        chk("mul_off_latency", 64'(out_valid), 64'd1);
        drain();
`else
        // DIVU latency XLEN+2, not ready while busy
        send(alu(ALU_OP_DIVU, 32'd100, 32'd7, 32'd14));
        lat = 1; bad = 0;
        @(negedge clk);
        while (!out_valid && lat < 200) begin
            if (in_ready) bad = 1;
            @(negedge clk);
            lat++;
        end
        chk("divu_latency", 64'(lat), 64'(XLEN + 2));
        chk("busy_not_ready", 64'(bad), 64'd0);
        drain();

        // reset during BUSY aborts
        send(alu(ALU_OP_DIVU, 32'd1000, 32'd3, 32'd333));
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("rst_busy_valid", 64'(out_valid), 64'd0);
        chk("rst_busy_ready", 64'(in_ready), 64'd1);
        bad = 0;
        repeat (XLEN + 8) begin
            @(negedge clk);
            if (out_valid) bad = 1;
        end
        chk("rst_busy_no_stale", 64'(bad), 64'd0);
`endif

        // reset with a held result clears it
        @(posedge clk); #1 out_ready = 1'b0;
        send(alu(ALU_OP_ADD, 32'd1, 32'd1, 32'd2));
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("rst_held_clear", {31'h0, out_valid, result}, 64'd0);
        send(alu(ALU_OP_ADD, 32'd2, 32'd3, 32'd5));
        drain();

        // XLEN=64 instance
        t64("sd64", ALU_OP_SD, 64'h100, 64'h0, 64'h0, 8'hFF, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        t64("sw64", ALU_OP_SW, 64'h100, 64'h4, 64'h0, 8'hF0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        t64("ld64mis", ALU_OP_LD, 64'h104, 64'h0, 64'h0, 8'h00, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0);
        t64("add64", ALU_OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        t64("sra64", ALU_OP_SRA, 64'h8000_0000_0000_0000, 64'd60, 64'hFFFF_FFFF_FFFF_FFF8, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
